tpu_job_sequencer: RTL and testbench

TPU_JOB_SEQUENCER -- requirements
Module: tpu_job_sequencer

---
 rtl/tpu_ctrl_pkg.sv | 28 ++
 rtl/tpu_timeout_counter.sv | 39 +++
 rtl/tpu_job_sequencer.sv | 159 +++++++++++++++
 tb/tb_tpu_job_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_ctrl_pkg.sv
// Shared definitions for the TPU job sequencer: FSM state encoding,
// element-address width, default WAIT timeout and the job-size check.
package tpu_ctrl_pkg;

    // Width of the element address bus and of the beat counter.
    localparam int unsigned ADDR_WIDTH = 8;

    // Default number of WAIT cycles allowed before the job is failed.
    localparam int unsigned TIMEOUT_DEFAULT = 1024;

    typedef enum logic [3:0] {
        StIdle  = 4'd0,
        StLoadW = 4'd1,
        StGapW  = 4'd2,
        StLoadA = 4'd3,
        StGapA  = 4'd4,
        StStart = 4'd5,
        StWait  = 4'd6,
        StFin   = 4'd7,
        StErr   = 4'd8
    } state_e;

    // A job dimension is usable when it is non-zero and fits the array.
    function automatic logic size_ok(input logic [ADDR_WIDTH-1:0] n, input int unsigned max_n);
        return (n != '0) && (32'(n) <= max_n);
    endfunction

endpackage

// File: rtl/tpu_timeout_counter.sv
// WAIT-phase watchdog for the TPU job sequencer.
// Counts enabled cycles since the last clear; expired is high during the
// enabled cycle in which the count reaches LIMIT (i.e. the LIMIT-th cycle).
//
// Ports:
//   clk     - clock, rising edge
//   rst_n   - asynchronous active-low reset
//   clear   - synchronous clear of the cycle count
//   enable  - count this cycle
//   expired - LIMIT-th enabled cycle since clear
module tpu_timeout_counter #(
    parameter int unsigned LIMIT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count_q;

    // count_q holds the number of enabled cycles already completed, so the
    // current cycle is number count_q + 1.
    assign expired = enable && (count_q == CW'(LIMIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && !expired) begin
            count_q <= count_q + CW'(1);
        end
    end

endmodule

// File: rtl/tpu_job_sequencer.sv
// Host-to-TPU job sequencer. Accepts a job command carrying the matrix
// dimension n, streams n*n weights then n*n activations into the TPU as
// addressed write strobes, starts the computation, and waits for completion
// with a timeout. Reports success with job_done, rejection/timeout with
// job_error. Every output is registered.
//
// Ports:
//   clk, rst_n                 - clock and asynchronous active-low reset
//   cmd_valid/cmd_ready        - job command handshake, cmd_size = n
//   in_valid/in_ready/in_data  - element beat stream (weights then activations)
//   tpu_load_weight/activation - write strobes, with tpu_load_addr/tpu_load_data
//   tpu_start                  - one-cycle compute start pulse
//   tpu_matrix_size            - latched n of the current job
//   tpu_done                   - TPU completion, honoured only while waiting
//   busy                       - sequencer is not idle
//   job_done, job_error        - one-cycle completion / failure pulses
module tpu_job_sequencer
    import tpu_ctrl_pkg::*;
#(
    parameter int unsigned SIZE       = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned TIMEOUT    = TIMEOUT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [7:0]            cmd_size,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  tpu_load_weight,
    output logic                  tpu_load_activation,
    output logic [ADDR_WIDTH-1:0] tpu_load_addr,
    output logic [DATA_WIDTH-1:0] tpu_load_data,
    output logic                  tpu_start,
    output logic [7:0]            tpu_matrix_size,
    input  logic                  tpu_done,
    output logic                  busy,
    output logic                  job_done,
    output logic                  job_error
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] beat_cnt_q;
    logic [ADDR_WIDTH-1:0] last_idx_q;
    logic [ADDR_WIDTH-1:0] last_idx_d;
    logic                  cmd_acc;
    logic                  beat_acc;
    logic                  size_good;
    logic                  last_beat;
    logic                  wait_expired;

    // cmd_ready/in_ready are registered copies of the state decode, so they
    // are also the exact handshake qualifiers (both 0 while in reset).
    assign cmd_acc   = cmd_valid && cmd_ready;
    assign beat_acc  = in_valid && in_ready;
    assign size_good = size_ok(cmd_size, SIZE);
    assign last_beat = (beat_cnt_q == last_idx_q);

    // n <= 15, so n*n - 1 fits the 8-bit counter; only latched for good sizes.
    assign last_idx_d = (cmd_size * cmd_size) - 8'd1;

    tpu_timeout_counter #(
        .LIMIT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state_q != StWait),
        .enable  (state_q == StWait),
        .expired (wait_expired)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_acc) begin
                    state_d = size_good ? StLoadW : StErr;
                end
            end
            StLoadW: begin
                if (beat_acc && last_beat) begin
                    state_d = StGapW;
                end
            end
            StGapW: state_d = StLoadA;
            StLoadA: begin
                if (beat_acc && last_beat) begin
                    state_d = StGapA;
                end
            end
            StGapA:  state_d = StStart;
            StStart: state_d = StWait;
            StWait: begin
                // Completion takes priority over a coincident timeout.
                if (tpu_done) begin
                    state_d = StFin;
                end else if (wait_expired) begin
                    state_d = StErr;
                end
            end
            StFin:   state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q             <= StIdle;
            beat_cnt_q          <= '0;
            last_idx_q          <= '0;
            cmd_ready           <= 1'b0;
            in_ready            <= 1'b0;
            tpu_load_weight     <= 1'b0;
            tpu_load_activation <= 1'b0;
            tpu_load_addr       <= '0;
            tpu_load_data       <= '0;
            tpu_start           <= 1'b0;
            tpu_matrix_size     <= '0;
            busy                <= 1'b0;
            job_done            <= 1'b0;
            job_error           <= 1'b0;
        end else begin
            state_q <= state_d;

            // State-decoded outputs are registered from the next state so they
            // line up with the state they describe.
            cmd_ready <= (state_d == StIdle);
            in_ready  <= (state_d == StLoadW) || (state_d == StLoadA);
            busy      <= (state_d != StIdle);
            tpu_start <= (state_d == StStart);
            job_done  <= (state_d == StFin);
            job_error <= (state_d == StErr);

            // A strobe only ever follows an accepted beat; stalls give gaps.
            tpu_load_weight     <= beat_acc && (state_q == StLoadW);
            tpu_load_activation <= beat_acc && (state_q == StLoadA);
            if (beat_acc) begin
                tpu_load_addr <= beat_cnt_q;
                tpu_load_data <= in_data;
            end

            if (cmd_acc) begin
                beat_cnt_q <= '0;
                if (size_good) begin
                    tpu_matrix_size <= cmd_size;
                    last_idx_q      <= last_idx_d;
                end
            end else if ((state_q == StGapW) || (state_q == StGapA)) begin
                beat_cnt_q <= '0;
            end else if (beat_acc) begin
                beat_cnt_q <= last_beat ? '0 : beat_cnt_q + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_tpu_job_sequencer.sv
// Bench for tpu_job_sequencer (SIZE=4, DATA_WIDTH=8, TIMEOUT=16).
// The driver pushes the expected output events into a queue as it issues
// stimulus; a monitor pops and compares on every strobe/start/done/error,
// including the cycle distance from the previous event where it is fixed.
module tb_tpu_job_sequencer;

    localparam int unsigned SIZE = 4;
    localparam int unsigned DW   = 8;
    localparam int unsigned TMO  = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [7:0]    cmd_size = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          tpu_load_weight;
    logic          tpu_load_activation;
    logic [7:0]    tpu_load_addr;
    logic [DW-1:0] tpu_load_data;
    logic          tpu_start;
    logic [7:0]    tpu_matrix_size;
    logic          tpu_done = 1'b0;
    logic          busy;
    logic          job_done;
    logic          job_error;

    always #5 clk = ~clk;

    tpu_job_sequencer #(
        .SIZE       (SIZE),
        .DATA_WIDTH (DW),
        .TIMEOUT    (TMO)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .cmd_valid           (cmd_valid),
        .cmd_ready           (cmd_ready),
        .cmd_size            (cmd_size),
        .in_valid            (in_valid),
        .in_ready            (in_ready),
        .in_data             (in_data),
        .tpu_load_weight     (tpu_load_weight),
        .tpu_load_activation (tpu_load_activation),
        .tpu_load_addr       (tpu_load_addr),
        .tpu_load_data       (tpu_load_data),
        .tpu_start           (tpu_start),
        .tpu_matrix_size     (tpu_matrix_size),
        .tpu_done            (tpu_done),
        .busy                (busy),
        .job_done            (job_done),
        .job_error           (job_error)
    );

    typedef enum int {EvW, EvA, EvStart, EvDone, EvErr} ev_kind_e;
    typedef struct {
        ev_kind_e kind;
        int       addr;
        int       data;
        int       rel;   // required cycles since previous event, 0 = any
    } ev_t;

    ev_t exp_q[$];
    int  n_tests  = 0;
    int  n_fail   = 0;
    int  cyc      = 0;
    int  last_cyc = 0;

    logic [7:0] wv [4];
    logic [7:0] av [4];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_tests++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    task automatic bound_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: wait bound expired, got no response, required DUT response", name);
    endtask

    task automatic expect_ev(input ev_kind_e k, input int a, input int d, input int r);
        ev_t e;
        e.kind = k;
        e.addr = a;
        e.data = d;
        e.rel  = r;
        exp_q.push_back(e);
    endtask

    task automatic got_ev(input ev_kind_e k, input int a, input int d);
        ev_t e;
        int  rel;
        rel      = cyc - last_cyc;
        last_cyc = cyc;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: got %s addr=%0d data=%0d, required no event",
                     k.name(), a, d);
            return;
        end
        e = exp_q.pop_front();
        if (k != e.kind || a != e.addr || d != e.data) begin
            n_fail++;
            $display("FAIL sb_event: got %s addr=%0d data=%0d, required %s addr=%0d data=%0d",
                     k.name(), a, d, e.kind.name(), e.addr, e.data);
        end
        if (e.rel != 0) begin
            n_tests++;
            if (rel != e.rel) begin
                n_fail++;
                $display("FAIL sb_timing %s: got %0d cycles after previous event, required %0d",
                         k.name(), rel, e.rel);
            end
        end
    endtask

    // Monitor: samples registered outputs on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (tpu_load_weight)     got_ev(EvW, int'(tpu_load_addr), int'(tpu_load_data));
            if (tpu_load_activation) got_ev(EvA, int'(tpu_load_addr), int'(tpu_load_data));
            if (tpu_start)           got_ev(EvStart, 0, int'(tpu_matrix_size));
            if (job_done)            got_ev(EvDone, 0, 0);
            if (job_error)           got_ev(EvErr, 0, 0);
        end
    end

    // All driver tasks start and end on a falling edge.
    task automatic send_cmd(input logic [7:0] n, input bit hold);
        int t;
        t = 0;
        cmd_valid = 1'b1;
        cmd_size  = n;
        while (!cmd_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!cmd_ready) bound_fail("cmd_accept");
        @(negedge clk);
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [7:0] d);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) bound_fail("beat_accept");
        @(negedge clk);
    endtask

    task automatic load_phase(input ev_kind_e k, input logic [7:0] v [4], input int first_rel,
                              input int stall_after);
        for (int i = 0; i < 4; i++) begin
            expect_ev(k, i, int'(v[i]), (i == 0) ? first_rel : (i == stall_after + 1) ? 4 : 1);
            send_beat(v[i]);
            if (i == stall_after) begin
                in_valid = 1'b0;
                repeat (3) @(negedge clk);
            end
        end
        in_valid = 1'b0;
    endtask

    // mode 0: done after 3 WAIT cycles; 1: timeout; 2: done in the last WAIT cycle.
    task automatic finish_job(input int mode, input logic [7:0] n);
        int t;
        t = 0;
        expect_ev(EvStart, 0, int'(n), 1);
        while (!tpu_start && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!tpu_start) bound_fail("start_seen");
        if (mode == 0) begin
            expect_ev(EvDone, 0, 0, 4);
            tpu_done = 1'b1;          // during START, must be ignored
            @(negedge clk);
            tpu_done = 1'b0;
            repeat (2) @(negedge clk);
            tpu_done = 1'b1;
            @(negedge clk);
            tpu_done = 1'b0;
        end else if (mode == 1) begin
            expect_ev(EvErr, 0, 0, TMO + 1);
            tpu_done = 1'b0;
            repeat (TMO + 1) @(negedge clk);
        end else begin
            expect_ev(EvDone, 0, 0, TMO + 1);
            repeat (TMO) @(negedge clk);
            tpu_done = 1'b1;
            @(negedge clk);
            tpu_done = 1'b0;
        end
        @(negedge clk);
        check("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("idle_busy", {31'd0, busy}, 32'd0);
    endtask

    task automatic run_job(input int stall_after, input int mode);
        send_cmd(8'd2, 1'b0);
        load_phase(EvW, wv, 0, stall_after);
        load_phase(EvA, av, 2, -1);
        finish_job(mode, 8'd2);
    endtask

    task automatic bad_cmd(input logic [7:0] n);
        expect_ev(EvErr, 0, 0, 0);
        send_cmd(n, 1'b0);
        check("err_cmd_ready_low", {31'd0, cmd_ready}, 32'd0);
        @(negedge clk);
        check("err_cmd_ready_back", {31'd0, cmd_ready}, 32'd1);
    endtask

    function automatic logic [31:0] all_outs();
        return {cmd_ready, in_ready, tpu_load_weight, tpu_load_activation, tpu_load_addr,
                tpu_load_data, tpu_start, tpu_matrix_size, busy, job_done, job_error};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        wv[0] = 8'd5; wv[1] = 8'd7; wv[2] = 8'd6; wv[3] = 8'd8;
        av[0] = 8'd1; av[1] = 8'd2; av[2] = 8'd3; av[3] = 8'd4;

        // Reset state and release.
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", all_outs(), 32'd0);
        rst_n = 1'b1;
        check("release_cmd_ready_before_edge", {31'd0, cmd_ready}, 32'd0);
        @(negedge clk);
        check("release_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("release_busy", {31'd0, busy}, 32'd0);

        // Back-to-back 2x2 job, then the same job with a 3-cycle stall after beat 1.
        run_job(-1, 0);
        run_job(1, 0);

        // Rejected sizes.
        bad_cmd(8'd0);
        bad_cmd(8'd5);

        // WAIT timeout, and done arriving in the final WAIT cycle.
        run_job(-1, 1);
        run_job(-1, 2);

        // Reset during activation beat 2.
        send_cmd(8'd2, 1'b0);
        load_phase(EvW, wv, 0, -1);
        expect_ev(EvA, 0, 1, 2);
        send_beat(8'd1);
        expect_ev(EvA, 1, 2, 1);
        send_beat(8'd2);
        check("busy_before_reset", {31'd0, busy}, 32'd1);
        in_data = 8'd3;
        #2 rst_n = 1'b0;
        #1 check("midjob_reset_outputs", all_outs(), 32'd0);
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("post_reset_in_ready", {31'd0, in_ready}, 32'd0);
        run_job(-1, 0);

        // cmd_valid held high across a whole job.
        send_cmd(8'd2, 1'b1);
        check("hold_cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
        check("hold_busy", {31'd0, busy}, 32'd1);
        load_phase(EvW, wv, 0, -1);
        check("hold_cmd_ready_loading", {31'd0, cmd_ready}, 32'd0);
        load_phase(EvA, av, 2, -1);
        finish_job(0, 8'd2);
        @(negedge clk);
        check("hold_second_accept_in_ready", {31'd0, in_ready}, 32'd1);
        check("hold_second_accept_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        cmd_valid = 1'b0;
        load_phase(EvW, wv, 0, -1);
        load_phase(EvA, av, 2, -1);
        finish_job(0, 8'd2);

        repeat (5) @(negedge clk);
        check("sb_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
